cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Multi-cycle control unit that sequences the 16-bit CPU datapath: the 16-entry register file, the 8-function ALU and the data memory. It owns the program counter (PC) and instruction register (IR) and fetches from a synchronous instruction ROM. It decodes each instruction and, one state per step, drives register-file addresses and enables, ALU function select, write-back mux select and data-memory controls. It sits at the top of the CPU beside the datapath and has no handshake with other blocks.

## Interface
- PC_W, 7: PC / instruction-address width; ROM depth 2^PC_W.
- Clk  input  1  rising-edge clock.
- ResetN  input  1  asynchronous, active-low reset.
- IM_Addr  output  PC_W  instruction ROM address; always equals PC.
- IM_Q  input  16  ROM read data; registered ROM, valid 1 cycle after IM_Addr changes.
- D_Addr  output  8  data-memory address.
- D_Wr  output  1  data-memory write enable.
- RF_s  output  1  RF write-data mux select; 1 = data memory, 0 = ALU Q.
- RF_W_Addr  output  4  RF write address.
- RF_W_en  output  1  RF write enable.
- RF_Ra_Addr  output  4  RF read port A address (ALU A / memory write data).
- RF_Rb_Addr  output  4  RF read port B address (ALU B).
- ALU_Sel  output  3  ALU function: 0 zero, 1 A+B, 2 A-B, 3 A, 4 A^B, 5 A|B, 6 A&B, 7 A+1.
- Halted  output  1  high while in HALT.
- Illegal  output  1  one-cycle pulse when an undefined opcode executes.
- State  output  4  current state encoding, for debug.

## Operation
- IR format: op=IR[15:12], ra=IR[11:8], rb=IR[7:4], rd=IR[3:0].
- Opcodes:
  - 0000 NOOP.
  - 0001 LOAD: RF[rd] <- D[IR[11:4]].
  - 0010 STORE: D[IR[7:0]] <- RF[ra].
  - 0011 ADD, sel 1.
  - 0100 SUB, sel 2.
  - 0101 MOV, sel 3.
  - 0110 XOR, sel 4.
  - 0111 OR, sel 5.
  - 1000 AND, sel 6.
  - 1001 INC, sel 7.
  - 1111 HALT.
  - 1010–1110 illegal.
- ALU ops: RF[rd] <- ALU(RF[ra], RF[rb]).
- States and encodings: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ALU 7, HALT 8.
- Transitions:
  - INIT -> FETCH.
  - FETCH -> DECODE.
  - DECODE -> by op: 0001 LOAD_A; 0010 STORE; 0011–1001 ALU; 1111 HALT; 0000 and 1010–1110 NOOP.
  - LOAD_A -> LOAD_B.
  - LOAD_B, STORE, ALU, NOOP -> FETCH.
  - HALT -> HALT, exited only by reset.
- Register actions:
  - FETCH: IR <= IM_Q; PC <= PC+1 modulo 2^PC_W (max value wraps to 0).
  - No other state changes PC or IR.
- Outputs are Moore, decoded from state and IR. Every enable is 0 and every address/select is 0 except as listed:
  - LOAD_A: D_Addr=IR[11:4].
  - LOAD_B: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=rd, RF_W_en=1.
  - STORE: D_Addr=IR[7:0], RF_Ra_Addr=ra, D_Wr=1.
  - ALU: RF_Ra_Addr=ra, RF_Rb_Addr=rb, ALU_Sel=op-2, RF_s=0, RF_W_Addr=rd, RF_W_en=1.
  - NOOP: Illegal=1 iff op in 1010–1110.
  - HALT: Halted=1.
- Control only: the block performs no arithmetic besides the PC increment.

## Timing
- Reset (ResetN low, asynchronous): State=INIT, PC=0, IR=0. All outputs 0: IM_Addr=0, D_Wr=0, RF_W_en=0, ALU_Sel=0, Halted=0, Illegal=0.
- Reset release mid-instruction: the aborted instruction has no further effect. Restart always begins at INIT with PC=0.
- INIT gives the ROM one cycle for address 0, so IM_Q is valid at the first FETCH. PC changes only in FETCH, so IM_Q is valid at every later FETCH.
- Cycles per instruction:
  - NOOP, STORE, ALU: 3 (FETCH, DECODE, exec).
  - LOAD: 4.
  - HALT: 2 to reach HALT.
- LOAD timing: data memory is synchronous-read. The address is presented in LOAD_A and held in LOAD_B; RF captures D_Q at the end of LOAD_B.
- RF and memory writes occur at the rising edge ending the exec state.

## Test plan
- Reset: assert ResetN=0 mid-ALU state -> all outputs 0 immediately. After release: INIT then FETCH with IM_Addr=0.
- ALU sequence: ROM[0]=0x3125 (ADD r5=r1+r2), ROM[1]=0x4125 -> ALU states show ALU_Sel=1 then 2, RF_Ra_Addr=1, RF_Rb_Addr=2, RF_W_Addr=5, RF_W_en=1 for one cycle each. Instructions are 3 cycles apart. Include INC 0x9307 -> ALU_Sel=7.
- LOAD: ROM[0]=0x1A53 -> D_Addr=0xA5 in LOAD_A and LOAD_B; RF_s=1, RF_W_en=1, RF_W_Addr=3 only in LOAD_B. Next FETCH at cycle 4.
- STORE and illegal: 0x2640 -> D_Wr=1, D_Addr=0x40, RF_Ra_Addr=6 for one cycle, RF_W_en=0. Opcode 0xB000 -> Illegal pulses 1 cycle, no write enables asserted.
- HALT: 0xF000 at address 3 -> Halted=1 persists, PC stays 4, no further enables. ResetN pulse -> restart at 0.
- PC wrap: PC_W=2, ROM all NOOP -> IM_Addr sequence 0,1,2,3,0 over 12 fetches, no stall.

Source files
------------

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle control unit for the 16-bit CPU datapath
module cpu_control_unit #(
   parameter int PC_W = 7
) (
   input  logic            Clk,
   input  logic            ResetN,
   output logic [PC_W-1:0] IM_Addr,
   input  logic [15:0]     IM_Q,
   output logic [7:0]      D_Addr,
   output logic            D_Wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_Addr,
   output logic            RF_W_en,
   output logic [3:0]      RF_Ra_Addr,
   output logic [3:0]      RF_Rb_Addr,
   output logic [2:0]      ALU_Sel,
   output logic            Halted,
   output logic            Illegal,
   output logic [3:0]      State
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ALU    = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [3:0]      op, ra, rb, rd;

   assign op = ir_q[15:12];
   assign ra = ir_q[11:8];
   assign rb = ir_q[7:4];
   assign rd = ir_q[3:0];

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= S_INIT;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH: begin
            ir_d    = IM_Q;
            pc_d    = pc_q + PC_W'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (op)
               4'h1:                                          state_d = S_LOAD_A;
               4'h2:                                          state_d = S_STORE;
               4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9:       state_d = S_ALU;
               4'hF:                                          state_d = S_HALT;
               default:                                       state_d = S_NOOP;
            endcase
         end
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B, S_STORE, S_ALU, S_NOOP: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   // Moore outputs: decoded only from the current state and the held IR
   always_comb begin
      D_Addr     = 8'd0;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_Addr  = 4'd0;
      RF_W_en    = 1'b0;
      RF_Ra_Addr = 4'd0;
      RF_Rb_Addr = 4'd0;
      ALU_Sel    = 3'd0;
      Halted     = 1'b0;
      Illegal    = 1'b0;
      case (state_q)
         S_LOAD_A: D_Addr = ir_q[11:4];
         S_LOAD_B: begin
            D_Addr    = ir_q[11:4];
            RF_s      = 1'b1;
            RF_W_Addr = rd;
            RF_W_en   = 1'b1;
         end
         S_STORE: begin
            D_Addr     = ir_q[7:0];
            RF_Ra_Addr = ra;
            D_Wr       = 1'b1;
         end
         S_ALU: begin
            RF_Ra_Addr = ra;
            RF_Rb_Addr = rb;
            ALU_Sel    = op[2:0] - 3'd2;
            RF_W_Addr  = rd;
            RF_W_en    = 1'b1;
         end
         S_NOOP:  Illegal = (op >= 4'hA) && (op <= 4'hE);
         S_HALT:  Halted  = 1'b1;
         default: ;
      endcase
   end

   assign IM_Addr = pc_q;
   assign State   = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - scoreboard bench for cpu_control_unit against an instruction-level model
module tb_cpu_control_unit;

   logic        Clk = 1'b0;
   logic        ResetN = 1'b0;
   logic [6:0]  IM_Addr;
   logic [15:0] IM_Q = 16'h0;
   logic [7:0]  D_Addr;
   logic        D_Wr, RF_s, RF_W_en, Halted, Illegal;
   logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, State;
   logic [2:0]  ALU_Sel;

   logic        rst2_n = 1'b0;
   logic [1:0]  im_addr2;
   logic [7:0]  d_addr2;
   logic        d_wr2, rf_s2, rf_w_en2, halted2, illegal2;
   logic [3:0]  rf_w_addr2, rf_ra_addr2, rf_rb_addr2, state2;
   logic [2:0]  alu_sel2;

   always #5 Clk = ~Clk;

   cpu_control_unit #(.PC_W(7)) u_dut (
      .Clk(Clk), .ResetN(ResetN), .IM_Addr(IM_Addr), .IM_Q(IM_Q),
      .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_Addr(RF_W_Addr),
      .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
      .ALU_Sel(ALU_Sel), .Halted(Halted), .Illegal(Illegal), .State(State)
   );

   cpu_control_unit #(.PC_W(2)) u_dut2 (
      .Clk(Clk), .ResetN(rst2_n), .IM_Addr(im_addr2), .IM_Q(16'h0000),
      .D_Addr(d_addr2), .D_Wr(d_wr2), .RF_s(rf_s2), .RF_W_Addr(rf_w_addr2),
      .RF_W_en(rf_w_en2), .RF_Ra_Addr(rf_ra_addr2), .RF_Rb_Addr(rf_rb_addr2),
      .ALU_Sel(alu_sel2), .Halted(halted2), .Illegal(illegal2), .State(state2)
   );

   logic [15:0] rom [128];
   always @(posedge Clk) IM_Q <= rom[IM_Addr];

   logic [38:0] exp_q [$];
   int          q2_cyc [$];
   int          q2_addr [$];
   int          errors = 0;
   int          checks = 0;
   int          tmo_req = 0;
   int          tmo_ack = 0;
   int          gen_left = 0;

   function automatic logic [38:0] rec(input int st, input int im, input int da, input int dwr,
                                       input int rfs, input int wa, input int wen, input int ra,
                                       input int rb, input int sel, input int hlt, input int ill);
      return {4'(st), 7'(im), 8'(da), 1'(dwr), 1'(rfs), 4'(wa), 1'(wen),
              4'(ra), 4'(rb), 3'(sel), 1'(hlt), 1'(ill)};
   endfunction

   task automatic push(input logic [38:0] r);
      if (gen_left > 0) begin
         exp_q.push_back(r);
         gen_left--;
      end
   endtask

   // Instruction-level model: expands the ROM program into the per-cycle output trace
   task automatic gen(input int n);
      int          pc;
      int          op;
      bit          halted;
      logic [15:0] ir;
      gen_left = n;
      pc = 0;
      halted = 0;
      push(rec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      while (gen_left > 0) begin
         if (halted) push(rec(8, pc, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         else begin
            ir = rom[pc];
            push(rec(1, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            pc = (pc + 1) % 128;
            push(rec(2, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            op = int'(ir[15:12]);
            if (op == 1) begin
               push(rec(4, pc, int'(ir[11:4]), 0, 0, 0, 0, 0, 0, 0, 0, 0));
               push(rec(5, pc, int'(ir[11:4]), 0, 1, int'(ir[3:0]), 1, 0, 0, 0, 0, 0));
            end else if (op == 2)
               push(rec(6, pc, int'(ir[7:0]), 1, 0, 0, 0, int'(ir[11:8]), 0, 0, 0, 0));
            else if (op >= 3 && op <= 9)
               push(rec(7, pc, 0, 0, 0, int'(ir[3:0]), 1, int'(ir[11:8]), int'(ir[7:4]), op - 2, 0, 0));
            else if (op == 15)
               halted = 1;
            else
               push(rec(3, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, (op >= 10) ? 1 : 0));
         end
      end
   endtask

   // Monitor: the only process that compares and counts
   initial begin
      logic [38:0] e, a;
      int          cyc2, ec, ea;
      int          step;
      cyc2 = 0;
      step = 0;
      forever begin
         @(negedge Clk);
         if (tmo_req != tmo_ack) begin
            tmo_ack = tmo_req;
            checks++;
            errors++;
            $display("FAIL drain_timeout: expectations still queued, required none");
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {State, IM_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
                 RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, Halted, Illegal};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL trace step %0d: got state=%0d out=%h, expected state=%0d out=%h",
                        step, a[38:35], a, e[38:35], e);
            end
            step++;
         end
         if (!rst2_n) cyc2 = 0;
         else begin
            if (state2 == 4'd1 && q2_cyc.size() > 0) begin
               ec = q2_cyc.pop_front();
               ea = q2_addr.pop_front();
               checks++;
               if (cyc2 != ec || int'(im_addr2) != ea) begin
                  errors++;
                  $display("FAIL pc_wrap fetch: got cycle=%0d addr=%0d, expected cycle=%0d addr=%0d",
                           cyc2, im_addr2, ec, ea);
               end
            end
            cyc2++;
         end
      end
   end

   task automatic drain(input int lim);
      for (int i = 0; i < lim && exp_q.size() > 0; i++) begin
         @(negedge Clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         exp_q.delete();
         tmo_req++;
      end
   endtask

   task automatic start_prog(input int n);
      ResetN = 1'b0;
      repeat (2) @(posedge Clk);
      #2;
      gen(n);
      ResetN = 1'b1;
   endtask

   task automatic run_prog(input int n);
      start_prog(n);
      drain(n + 5);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
   endtask

   initial begin
      int lim;
      clear_rom();

      // PC_W=2 instance: 12 fetches, 3 cycles apart, address wraps 3 -> 0
      repeat (2) @(posedge Clk);
      #2;
      for (int k = 0; k < 12; k++) begin
         q2_cyc.push_back(1 + 3 * k);
         q2_addr.push_back(k % 4);
      end
      rst2_n = 1'b1;
      lim = 0;
      while (q2_cyc.size() > 0 && lim < 60) begin
         @(negedge Clk);
         #1;
         lim++;
      end
      if (q2_cyc.size() > 0) begin
         q2_cyc.delete();
         q2_addr.delete();
         tmo_req++;
      end

      // Reset asserted asynchronously inside the ALU state
      clear_rom();
      rom[0] = 16'h3125;
      start_prog(3);
      drain(10);
      @(posedge Clk);
      #1;
      ResetN = 1'b0;
      exp_q.push_back(rec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drain(4);

      clear_rom();
      rom[0] = 16'h3125; rom[1] = 16'h4125; rom[2] = 16'h9307;
      run_prog(14);

      clear_rom();
      rom[0] = 16'h1A53;
      run_prog(12);

      clear_rom();
      rom[0] = 16'h2640; rom[1] = 16'hB000; rom[2] = 16'hE123; rom[3] = 16'hF000;
      run_prog(30);
      run_prog(8);

      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 128; i++)
            rom[i] = {4'($urandom_range(0, 15)), 12'($urandom)};
         run_prog(80);
      end

      for (int i = 0; i < 128; i++)
         rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_prog(450);

      @(negedge Clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
